// File: rtl/fifo_seq_ctrl.sv
// Burst sequencer for a FIFO: writes an incrementing pattern, reads it back and checks it,
// and aborts a burst that stalls on full/empty for too long.
module fifo_seq_ctrl #(
    parameter int unsigned DSIZE  = 3,
    parameter int unsigned ASIZE  = 3,
    parameter int unsigned TO_CYC = 255
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             start_wr,
    input  logic             start_rd,
    input  logic [ASIZE:0]   burst_len,
    input  logic [DSIZE-1:0] seed,
    input  logic             wfull,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    output logic             rinc,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             timeout
);

    localparam int unsigned SW = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e           state_q, state_d;
    logic [ASIZE:0]   remaining_q, remaining_d;
    logic [DSIZE-1:0] pattern_q, pattern_d;
    logic [SW-1:0]    stall_q, stall_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             timeout_q, timeout_d;
    logic             xfer_ready;
    logic             winc_c, rinc_c;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pattern_d   = pattern_q;
        stall_d     = stall_q;
        done_d      = 1'b0;
        err_d       = err_q;
        timeout_d   = timeout_q;
        winc_c      = 1'b0;
        rinc_c      = 1'b0;
        xfer_ready  = (state_q == StWrite) ? !wfull : !rempty;

        unique case (state_q)
            StIdle: begin
                // A simultaneous request resolves to a write; the read request is dropped.
                if (start_wr || start_rd) begin
                    state_d     = start_wr ? StWrite : StRead;
                    remaining_d = burst_len;
                    pattern_d   = seed;
                    stall_d     = '0;
                end
            end
            StWrite, StRead: begin
                if (remaining_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (xfer_ready) begin
                    if (state_q == StWrite) begin
                        winc_c = 1'b1;
                    end else begin
                        rinc_c = 1'b1;
                        if (rdata != pattern_q) err_d = 1'b1;
                    end
                    pattern_d   = pattern_q + DSIZE'(1);
                    remaining_d = remaining_q - (ASIZE + 1)'(1);
                    stall_d     = '0;
                    if (remaining_q == (ASIZE + 1)'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else if (stall_q == SW'(TO_CYC - 1)) begin
                    // This cycle is the TO_CYC-th consecutive stall: abort without done.
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                    stall_d   = '0;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            pattern_q   <= '0;
            stall_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pattern_q   <= pattern_d;
            stall_q     <= stall_d;
            done_q      <= done_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
        end
    end

    // Strobes are gated by reset so a mid-burst reset stops transfers in the same cycle.
    assign winc    = winc_c & ~reset;
    assign rinc    = rinc_c & ~reset;
    assign wdata   = pattern_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign err     = err_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_fifo_seq_ctrl.sv
// Directed self-checking bench for fifo_seq_ctrl: write/read bursts, wrap, mismatch, timeout,
// start collisions and mid-burst reset.
module tb_fifo_seq_ctrl;

    localparam int unsigned DSIZE  = 3;
    localparam int unsigned ASIZE  = 3;
    localparam int unsigned TO_CYC = 255;

    logic             clk_100MHz = 1'b0;
    logic             reset;
    logic             start_wr;
    logic             start_rd;
    logic [ASIZE:0]   burst_len;
    logic [DSIZE-1:0] seed;
    logic             wfull;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             rinc;
    logic             busy;
    logic             done;
    logic             err;
    logic             timeout;

    int checks   = 0;
    int failures = 0;

    logic [DSIZE-1:0] fifo_q[$];

    always #5 clk_100MHz = ~clk_100MHz;

    fifo_seq_ctrl #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE),
        .TO_CYC(TO_CYC)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .start_wr  (start_wr),
        .start_rd  (start_rd),
        .burst_len (burst_len),
        .seed      (seed),
        .wfull     (wfull),
        .rempty    (rempty),
        .rdata     (rdata),
        .winc      (winc),
        .wdata     (wdata),
        .rinc      (rinc),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_100MHz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wcnt;
        int rcnt;
        int early;
        logic [DSIZE-1:0] exp_wd37[4];
        logic [DSIZE-1:0] exp_wd38[4];
        logic [DSIZE-1:0] rd39[3];
        logic             err39[3];

        exp_wd37 = '{3'd3, 3'd4, 3'd5, 3'd6};
        exp_wd38 = '{3'd6, 3'd7, 3'd0, 3'd1};
        rd39     = '{3'd2, 3'd5, 3'd4};
        err39    = '{1'b0, 1'b0, 1'b1};

        reset = 1'b1; start_wr = 1'b0; start_rd = 1'b0; burst_len = '0; seed = '0;
        wfull = 1'b0; rempty = 1'b1; rdata = '0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_winc", winc, 0);
        chk("rst_rinc", rinc, 0);
        chk("rst_wdata", wdata, 0);

        // Basic write burst: seed 3, length 4
        cyc(); reset = 1'b0; seed = 3'd3; burst_len = 4'd4; start_wr = 1'b1; #1;
        chk("idle_winc", winc, 0);
        cyc(); start_wr = 1'b0; seed = '0; burst_len = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("w37_winc", winc, 1);
            chk("w37_wdata", wdata, exp_wd37[i]);
            chk("w37_busy", busy, 1);
            cyc();
        end
        #1;
        chk("w37_done", done, 1);
        chk("w37_busy_end", busy, 0);
        chk("w37_winc_end", winc, 0);
        cyc(); #1;
        chk("w37_done_pulse", done, 0);

        // Zero-length burst
        start_wr = 1'b1; burst_len = '0;
        cyc(); start_wr = 1'b0; #1;
        chk("z_busy", busy, 1);
        chk("z_winc", winc, 0);
        cyc(); #1;
        chk("z_done", done, 1);
        chk("z_busy_end", busy, 0);

        // Write with wrap, then read back through a model FIFO
        cyc(); seed = 3'd6; burst_len = 4'd4; start_wr = 1'b1;
        cyc(); start_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("w38_winc", winc, 1);
            chk("w38_wdata", wdata, exp_wd38[i]);
            if (winc) fifo_q.push_back(wdata);
            cyc();
        end
        #1;
        chk("w38_done", done, 1);
        cyc(); seed = 3'd6; burst_len = 4'd4; start_rd = 1'b1;
        rempty = (fifo_q.size() == 0); rdata = fifo_q[0]; #1;
        chk("r38_idle_rinc", rinc, 0);
        cyc(); start_rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rempty = (fifo_q.size() == 0);
            rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
            #1;
            chk("r38_rinc", rinc, 1);
            chk("r38_winc", winc, 0);
            if (rinc && fifo_q.size() != 0) void'(fifo_q.pop_front());
            cyc();
        end
        rempty = 1'b1; #1;
        chk("r38_done", done, 1);
        chk("r38_err", err, 0);
        chk("r38_rinc_end", rinc, 0);

        // Read mismatch sets sticky err
        cyc(); seed = 3'd2; burst_len = 4'd3; start_rd = 1'b1; rempty = 1'b0; rdata = 3'd2;
        cyc(); start_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rdata = rd39[i]; #1;
            chk("r39_rinc", rinc, 1);
            chk("r39_err_pre", err, err39[i]);
            cyc();
        end
        rempty = 1'b1; #1;
        chk("r39_err", err, 1);
        chk("r39_done", done, 1);
        cyc(); seed = '0; burst_len = 4'd1; start_wr = 1'b1;
        cyc(); start_wr = 1'b0; #1;
        chk("r39_w_winc", winc, 1);
        cyc(); #1;
        chk("r39_w_done", done, 1);
        chk("r39_err_sticky", err, 1);
        reset = 1'b1;
        cyc(); reset = 1'b0; #1;
        chk("r39_err_cleared", err, 0);

        // Stall timeout: two transfers, then wfull held high
        seed = '0; burst_len = 4'd8; start_wr = 1'b1; wfull = 1'b0;
        wcnt = 0; early = 0;
        cyc(); start_wr = 1'b0; #1;
        wcnt += int'(winc);
        cyc(); #1;
        wcnt += int'(winc);
        cyc(); wfull = 1'b1;
        for (int k = 0; k < 255; k++) begin
            #1;
            wcnt  += int'(winc);
            early += int'(timeout);
            cyc();
        end
        #1;
        chk("t40_wcnt", wcnt, 2);
        chk("t40_early", early, 0);
        chk("t40_timeout", timeout, 1);
        chk("t40_busy", busy, 0);
        chk("t40_done", done, 0);
        cyc(); wfull = 1'b0; #1;
        chk("t40_done_after", done, 0);
        chk("t40_timeout_sticky", timeout, 1);
        reset = 1'b1;
        cyc(); reset = 1'b0; #1;
        chk("t40_timeout_cleared", timeout, 0);

        // Simultaneous starts, then start_rd during WRITE
        seed = 3'd1; burst_len = 4'd2; start_wr = 1'b1; start_rd = 1'b1;
        rempty = 1'b0; rdata = 3'd1; wcnt = 0; rcnt = 0;
        cyc(); start_wr = 1'b0; start_rd = 1'b1; #1;
        wcnt += int'(winc); rcnt += int'(rinc);
        cyc(); start_rd = 1'b0; #1;
        wcnt += int'(winc); rcnt += int'(rinc);
        cyc(); #1;
        rcnt += int'(rinc);
        chk("c41_done", done, 1);
        cyc(); #1;
        rcnt += int'(rinc);
        cyc(); #1;
        rcnt += int'(rinc);
        chk("c41_busy", busy, 0);
        chk("c41_wcnt", wcnt, 2);
        chk("c41_rcnt", rcnt, 0);
        rempty = 1'b1;

        // Reset during the third transfer of a 6-long write
        cyc(); seed = '0; burst_len = 4'd6; start_wr = 1'b1;
        cyc(); start_wr = 1'b0; #1;
        chk("x42_t1", winc, 1);
        cyc(); #1;
        chk("x42_t2", winc, 1);
        cyc(); reset = 1'b1; #1;
        chk("x42_winc_in_rst", winc, 0);
        cyc(); reset = 1'b0; #1;
        chk("x42_busy", busy, 0);
        chk("x42_winc", winc, 0);
        chk("x42_done", done, 0);
        chk("x42_wdata", wdata, 0);
        cyc(); #1;
        chk("x42_done_after", done, 0);
        chk("x42_winc_after", winc, 0);
        seed = 3'd5; burst_len = 4'd1; start_wr = 1'b1;
        cyc(); start_wr = 1'b0; #1;
        chk("x42_restart_busy", busy, 1);
        chk("x42_restart_winc", winc, 1);
        chk("x42_restart_wdata", wdata, 5);
        cyc(); #1;
        chk("x42_restart_done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_seq_ctrl.md
FIFO_SEQ_CTRL -- requirements
Module: fifo_seq_ctrl

Interface
REQ-001 SHALL have parameter DSIZE, default 3, FIFO data width.
REQ-002 SHALL have parameter ASIZE, default 3, FIFO address width; burst length counts up to 2^(ASIZE+1)-1.
REQ-003 SHALL have parameter TO_CYC, default 255, maximum consecutive stall cycles before abort.
REQ-004 clk_100MHz  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start_wr  in  1  one-cycle pulse (debounced), requests a write burst.
REQ-007 start_rd  in  1  one-cycle pulse (debounced), requests a read burst.
REQ-008 burst_len  in  ASIZE+1  transfers per burst, sampled at burst start.
REQ-009 seed  in  DSIZE  pattern start value, sampled at write or read burst start.
REQ-010 wfull  in  1  FIFO full flag.
REQ-011 rempty  in  1  FIFO empty flag.
REQ-012 rdata  in  DSIZE  FIFO read data, valid while rempty=0, before rinc.
REQ-013 winc  out  1  FIFO write enable.
REQ-014 wdata  out  DSIZE  FIFO write data.
REQ-015 rinc  out  1  FIFO read enable.
REQ-016 busy  out  1  high in WRITE or READ state.
REQ-017 done  out  1  one-cycle pulse at burst completion.
REQ-018 err  out  1  sticky read-data mismatch flag.
REQ-019 timeout  out  1  sticky stall-abort flag.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, READ; encoding free.
REQ-021 IDLE: start_wr -> WRITE; else start_rd -> READ; both in the same cycle -> WRITE, start_rd dropped.
REQ-022 On entry, remaining count SHALL load burst_len and pattern register SHALL load seed.
REQ-023 burst_len=0 SHALL give no transfer, a done pulse the next cycle, and a return to IDLE.
REQ-024 start_wr/start_rd while busy=1 SHALL be ignored, not queued.
REQ-025 WRITE: winc=1 combinationally when wfull=0 and remaining>0; wdata=pattern register.
REQ-026 Each cycle with winc=1: pattern +1 (mod 2^DSIZE, wraps), remaining -1.
REQ-027 READ: rinc=1 combinationally when rempty=0 and remaining>0.
REQ-028 Each cycle with rinc=1: compare rdata to pattern; on mismatch set err; then pattern +1 mod 2^DSIZE, remaining -1.
REQ-029 When the last transfer completes (remaining 1->0), the FSM SHALL go to IDLE on that edge, with done=1 for the following cycle.
REQ-030 winc and rinc SHALL never both be 1; neither SHALL be 1 in IDLE.
REQ-031 Stall counter SHALL count cycles in WRITE with wfull=1 or READ with rempty=1; clear on any transfer or state entry.
REQ-032 When stall count reaches TO_CYC, SHALL set timeout, go to IDLE, with no done pulse.
REQ-033 err and timeout SHALL stay set until reset.
REQ-034 done SHALL be registered; winc/rinc SHALL be deasserted the same cycle the flag goes high (no write on full, no read on empty).

Reset
REQ-035 With reset=1 at an edge: state IDLE, remaining 0, pattern 0, stall 0, done/err/timeout 0; winc=rinc=0 combinationally during reset.
REQ-036 Reset mid-burst SHALL abort immediately, with no further winc/rinc and no done pulse.

Verification
REQ-037 seed=3, burst_len=4, start_wr, wfull=0 -> winc 4 consecutive cycles with wdata 3,4,5,6; done one cycle later; busy low.
REQ-038 seed=6, burst_len=4 write then read, model FIFO -> wdata 6,7,0,1 (wrap); read matches; err=0; two done pulses.
REQ-039 Read burst_len=3, seed=2, rdata forced 2,5,4 -> err=1 after second rinc and stays 1 through later bursts until reset.
REQ-040 Write burst_len=8, wfull held 1 from 3rd transfer, TO_CYC=255 -> exactly 2 winc, timeout=1 after 255 stall cycles, IDLE, no done.
REQ-041 start_wr and start_rd same cycle in IDLE, then start_rd during WRITE -> only write burst runs; rinc never asserted.
REQ-042 reset pulsed during 3rd transfer of burst_len=6 write -> winc low from that edge on, all outputs at reset values, next start_wr accepted.
